// File: rtl/seven_led_display_arbiter.sv
// rtl/seven_led_display_arbiter.sv - 4-digit 7-segment scan with status/message display arbitration
module seven_led_display_arbiter #(
    parameter int SCAN_DIV    = 14213,
    parameter int BLANK_CYC   = 64,
    parameter int HOLD_FRAMES = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [15:0] i_status,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_msg0,
    input  logic [15:0] i_msg1,
    output logic [1:0]  o_ack,
    output logic        o_busy,
    output logic [1:0]  o_src,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_dig
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_V   = SW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      slot;
    logic            boundary;
    logic [HW-1:0]   hold;
    logic [15:0]     buffer;
    logic [3:0]      cur_nib;
    logic            expiring;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 8'hC0;
            4'h1:    glyph = 8'hF9;
            4'h2:    glyph = 8'hA4;
            4'h3:    glyph = 8'hB0;
            4'h4:    glyph = 8'h99;
            4'h5:    glyph = 8'h92;
            4'h6:    glyph = 8'h82;
            4'h7:    glyph = 8'hF8;
            4'h8:    glyph = 8'h80;
            4'h9:    glyph = 8'h90;
            4'hA:    glyph = 8'hA1;
            4'hB:    glyph = 8'hE3;
            4'hC:    glyph = 8'hC7;
            4'hD:    glyph = 8'h92;
            4'hE:    glyph = 8'hBF;
            default: glyph = 8'hFF;
        endcase
    endfunction

    always_comb begin
        cur_nib = 4'hF;
        case (slot)
            2'd0:    cur_nib = buffer[15:12];
            2'd1:    cur_nib = buffer[11:8];
            2'd2:    cur_nib = buffer[7:4];
            default: cur_nib = buffer[3:0];
        endcase
    end

    assign expiring = (hold == HOLD_LAST);

    // Boundary flag is registered so the FSM acts in the slot-0/count-0 cycle, which is blanked.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
            boundary <= 1'b1;
            o_seg    <= 8'hFF;
            o_dig    <= 4'b1111;
        end else begin
            boundary <= (scan_cnt == SCAN_LAST) && (slot == 2'd3);
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            o_seg <= glyph(cur_nib);
            o_dig <= (scan_cnt >= BLANK_V) ? ~(4'b1000 >> slot) : 4'b1111;
        end
    end

    // A pending req1 takes over directly at the boundary where SHOW0 expires, avoiding a status gap frame.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            hold   <= '0;
            buffer <= 16'hFFFF;
            o_ack  <= 2'b00;
            o_busy <= 1'b0;
            o_src  <= 2'd0;
        end else begin
            o_ack <= 2'b00;
            if (boundary) begin
                if (i_req[0]) begin
                    o_ack  <= 2'b01;
                    buffer <= i_msg0;
                    state  <= SHOW0;
                    hold   <= '0;
                    o_busy <= 1'b1;
                    o_src  <= 2'd1;
                end else if (i_req[1] && ((state != SHOW0) || expiring)) begin
                    o_ack  <= 2'b10;
                    buffer <= i_msg1;
                    state  <= SHOW1;
                    hold   <= '0;
                    o_busy <= 1'b1;
                    o_src  <= 2'd2;
                end else if ((state != IDLE) && expiring) begin
                    buffer <= i_status;
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_src  <= 2'd0;
                end else if (state != IDLE) begin
                    hold <= hold + 1'b1;
                end else begin
                    buffer <= i_status;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_led_display_arbiter.sv
// tb/tb_seven_led_display_arbiter.sv - scoreboard bench for seven_led_display_arbiter
module tb_seven_led_display_arbiter;
    localparam int SCAN  = 4;
    localparam int BLANK = 1;
    localparam int HOLD  = 2;
    localparam int FRAME = 4 * SCAN;

    logic        i_clock;
    logic        i_reset_n;
    logic [15:0] i_status;
    logic [1:0]  i_req;
    logic [15:0] i_msg0;
    logic [15:0] i_msg1;
    logic [1:0]  o_ack;
    logic        o_busy;
    logic [1:0]  o_src;
    logic [7:0]  o_seg;
    logic [3:0]  o_dig;

    typedef struct packed {
        logic [1:0] ack;
        logic       busy;
        logic [1:0] src;
        logic [7:0] seg;
        logic [3:0] dig;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  seen_ack = 2'b00;
    bit          rand_mode = 0;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'hA1, 8'hE3, 8'hC7, 8'h92, 8'hBF, 8'hFF};

    seven_led_display_arbiter #(
        .SCAN_DIV(SCAN),
        .BLANK_CYC(BLANK),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .i_clock(i_clock),
        .i_reset_n(i_reset_n),
        .i_status(i_status),
        .i_req(i_req),
        .i_msg0(i_msg0),
        .i_msg1(i_msg1),
        .o_ack(o_ack),
        .o_busy(o_busy),
        .o_src(o_src),
        .o_seg(o_seg),
        .o_dig(o_dig)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Reference model: owner/elapsed-frame bookkeeping driven by edge count since reset release.
    initial begin
        int          k;
        int          owner;
        int          elapsed;
        logic [15:0] mbuf;
        bit          done;
        obs_t        e;
        int          c;
        int          s;
        logic [3:0]  nib;
        k = 0; owner = 0; elapsed = 0; mbuf = 16'hFFFF;
        forever begin
            @(posedge i_clock);
            if (!i_reset_n) begin
                k = 0; owner = 0; elapsed = 0; mbuf = 16'hFFFF;
            end else begin
                c = k % SCAN;
                s = (k / SCAN) % 4;
                e.dig = (c >= BLANK) ? ~(4'b1000 >> s) : 4'b1111;
                nib = 4'((mbuf >> (4 * (3 - s))) & 16'hF);
                e.seg = glyph_tab[nib];
                e.ack = 2'b00;
                if (k % FRAME == 0) begin
                    done = (owner != 0) && (elapsed + 1 >= HOLD);
                    if (i_req[0]) begin
                        owner = 1; elapsed = 0; mbuf = i_msg0; e.ack = 2'b01;
                    end else if (i_req[1] && (owner != 1 || done)) begin
                        owner = 2; elapsed = 0; mbuf = i_msg1; e.ack = 2'b10;
                    end else if (done) begin
                        owner = 0; mbuf = i_status;
                    end else if (owner != 0) begin
                        elapsed++;
                    end else begin
                        mbuf = i_status;
                    end
                end
                e.src = 2'(owner);
                e.busy = (owner != 0);
                exp_q.push_back(e);
                k++;
            end
        end
    end

    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge i_clock);
            #1;
            if (i_reset_n) begin
                a = '{ack: o_ack, busy: o_busy, src: o_src, seg: o_seg, dig: o_dig};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty t=%0t actual ack=%b busy=%b src=%0d seg=%h dig=%b",
                             $time, a.ack, a.busy, a.src, a.seg, a.dig);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL display_out t=%0t actual ack=%b busy=%b src=%0d seg=%h dig=%b required ack=%b busy=%b src=%0d seg=%h dig=%b",
                                 $time, a.ack, a.busy, a.src, a.seg, a.dig, e.ack, e.busy, e.src, e.seg, e.dig);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge i_clock);
            for (int i = 0; i < 2; i++) begin
                if (o_ack[i]) begin
                    seen_ack[i] = 1'b1;
                    i_req[i] = 1'b0;
                end
            end
            if (rand_mode) begin
                if ($urandom_range(0, 19) == 0) i_status = 16'($urandom);
                for (int i = 0; i < 2; i++) begin
                    if (!i_req[i] && !o_ack[i] && $urandom_range(0, 29) == 0) begin
                        if (i == 0) i_msg0 = 16'($urandom);
                        else        i_msg1 = 16'($urandom);
                        i_req[i] = 1'b1;
                    end else if (i_req[i] && $urandom_range(0, 99) == 0) begin
                        i_req[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic wait_ack(input int idx, input string name);
        int n;
        n = 0;
        seen_ack[idx] = 1'b0;
        while (!seen_ack[idx] && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (!seen_ack[idx]) begin
            failures++;
            $display("FAIL %s ack%0d actual=absent required=pulse within 200 cycles", name, idx);
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_status  = 16'h0A1B;
        i_req     = 2'b00;
        i_msg0    = 16'h0000;
        i_msg1    = 16'h0000;
        step(3);
        #1;
        check("reset_seg", {8'h00, o_seg}, 16'h00FF);
        check("reset_dig", {12'h000, o_dig}, 16'h000F);
        check("reset_ack", {14'h0, o_ack}, 16'h0000);
        check("reset_busy", {15'h0, o_busy}, 16'h0000);
        check("reset_src", {14'h0, o_src}, 16'h0000);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        step(40);

        step(5);
        i_msg0 = 16'hCDEF;
        i_req[0] = 1'b1;
        wait_ack(0, "msg0_mid_frame");
        step(50);

        step(3);
        i_msg0 = 16'h1234;
        i_msg1 = 16'h5678;
        i_req = 2'b11;
        wait_ack(0, "both_req0");
        wait_ack(1, "both_req1");
        step(40);

        i_msg1 = 16'h9ABC;
        i_req[1] = 1'b1;
        wait_ack(1, "show1_enter");
        step(20);
        i_msg0 = 16'h4321;
        i_req[0] = 1'b1;
        wait_ack(0, "preempt_show1");
        step(20);
        i_msg0 = 16'h8765;
        i_req[0] = 1'b1;
        wait_ack(0, "restart_show0");
        step(70);

        step(8);
        i_status = 16'h2468;
        step(40);

        i_msg0 = 16'hE0E0;
        i_req[0] = 1'b1;
        wait_ack(0, "pre_reset_show0");
        step(6);
        i_reset_n = 1'b0;
        i_req = 2'b00;
        #1;
        check("async_dig", {12'h000, o_dig}, 16'h000F);
        check("async_seg", {8'h00, o_seg}, 16'h00FF);
        check("async_busy", {15'h0, o_busy}, 16'h0000);
        check("async_src", {14'h0, o_src}, 16'h0000);
        check("async_ack", {14'h0, o_ack}, 16'h0000);
        step(3);
        i_reset_n = 1'b1;
        step(40);

        rand_mode = 1;
        step(3000);
        rand_mode = 0;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
